// File: rtl/cmp_scoreboard_pkg.sv
// cmp_scoreboard_pkg: result codes, display-select codes and active-low hex glyphs
package cmp_scoreboard_pkg;
  typedef logic [1:0] res_t;
  localparam res_t RES_NONE = 2'b00;
  localparam res_t RES_GT = 2'b01;
  localparam res_t RES_LT = 2'b10;
  localparam res_t RES_EQ = 2'b11;
  localparam logic [1:0] DSEL_GT = 2'b00;
  localparam logic [1:0] DSEL_LT = 2'b01;
  localparam logic [1:0] DSEL_EQ = 2'b10;
  localparam logic [1:0] DSEL_GT_ALIAS = 2'b11;
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/cmp_scoreboard_hex_to_seg7.sv
// hex_to_seg7: nib_i hex nibble + dp_i flag -> seg_o active-low {dp,g,f,e,d,c,b,a}
module hex_to_seg7
  import cmp_scoreboard_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  always_comb seg_o = {~dp_i, SEG_HEX[nib_i][6:0]};
endmodule

// File: rtl/cmp_scoreboard.sv
// cmp_scoreboard: a/b compared on in_valid into out/out_valid, gt/lt/eq saturating counters, disp_sel counter scanned onto seg7/an
module cmp_scoreboard
  import cmp_scoreboard_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGITS = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              signed_mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              clr,
  input  logic [1:0]        disp_sel,
  output logic [1:0]        out,
  output logic              out_valid,
  output logic [7:0]        seg7,
  output logic [DIGITS-1:0] an
);
  localparam int CW = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  res_t out_q, out_d, res;
  logic out_valid_q, out_valid_d, gt_raw, wrap, dp;
  logic [CW-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d, sel_cnt;
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] nib;
  always_comb begin
    out_valid_d = in_valid & ~clr;
    gt_raw = signed_mode ? $signed(a) > $signed(b) : a > b;
    res = a == b ? RES_EQ : gt_raw ? RES_GT : RES_LT;
    out_d = clr ? RES_NONE : out_valid_d ? res : out_q;
    gt_d = clr ? '0 : gt_q + CW'(out_valid_d && res == RES_GT && !(&gt_q));
    lt_d = clr ? '0 : lt_q + CW'(out_valid_d && res == RES_LT && !(&lt_q));
    eq_d = clr ? '0 : eq_q + CW'(out_valid_d && res == RES_EQ && !(&eq_q));
    sel_cnt = disp_sel == DSEL_LT ? lt_q : disp_sel == DSEL_EQ ? eq_q : gt_q;
    wrap = div_q == DW'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + DW'(1);
    idx_d = !wrap ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1);
    // seg7 and an are both derived from the next scan index so they always land together
    nib = 4'(sel_cnt >> (4 * idx_d));
    dp = idx_d == '0 && &sel_cnt;
    an_d = ~(DIGITS'(1) << idx_d);
  end
  hex_to_seg7 u_hex (.nib_i(nib), .dp_i(dp), .seg_o(seg_d));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q <= RES_NONE;
      out_valid_q <= 1'b0;
      gt_q <= '0;
      lt_q <= '0;
      eq_q <= '0;
      div_q <= '0;
      idx_q <= '0;
      an_q <= ~DIGITS'(1);
      seg_q <= SEG_HEX[0];
    end else begin
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
      div_q <= div_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign seg7 = seg_q;
  assign an = an_q;
endmodule

// File: doc/cmp_scoreboard.md
# cmp_scoreboard

Parametrised registered magnitude comparator with result counters and a multiplexed seven-segment scoreboard. Each accepted (a, b) sample is compared in signed or unsigned mode. Three saturating counters track how often A>B, A<B and A==B occurred, and the selected counter is shown in hex across DIGITS scanned seven-segment digits. It is the successor to the fixed 4-bit comparator/display top and sits directly behind board switches or a stimulus source, driving the display pins.

## Interface
- WIDTH, 4: operand width in bits (≥2)
- DIGITS, 2: display digits; counter width CW = 4*DIGITS
- SCAN_DIV, 4: clock cycles each digit stays active (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample a/b this cycle
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with in_valid
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- clr  in  1  synchronous clear of counters and result
- disp_sel  in  2  counter to display: 00 gt, 01 lt, 10 eq, 11 gt (alias)
- out  out  2  last result: 01 A>B, 10 A<B, 11 A==B, 00 none since reset/clr
- out_valid  out  1  one-cycle pulse when out updates
- seg7  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- an  out  DIGITS  active-low one-hot digit enable; bit 0 = least significant nibble

## Operation
- Reset values:
  - out=00, out_valid=0
  - all counters 0, scan index 0, scan divider 0
  - an = all ones except bit0 = 0
  - seg7 = 8'hC0 (glyph "0")
- Compare:
  - On each edge with in_valid=1 and clr=0, register out from a, b and signed_mode.
  - Pulse out_valid for exactly one cycle.
  - Increment the matching counter.
- Counters:
  - CW bits wide; saturate at all-ones (no wrap).
  - A sample at saturation leaves the counter unchanged; out and out_valid still update.
- clr=1: counters←0, out←00, out_valid←0. When clr and in_valid are both high, clr wins and the sample is discarded.
- Display:
  - The scan divider counts 0..SCAN_DIV-1. On wrap, the scan index advances modulo DIGITS (DIGITS-1 → 0).
  - Digit i shows nibble i of the counter selected by disp_sel; disp_sel takes effect on the next registered display update.
- Glyphs are standard hex, including 0=C0, 2=A4, 4=99, F=8E.
- dp is lit (bit7=0) on digit 0 only when the selected counter is saturated; otherwise bit7=1.
- seg7 and an are registered and always change on the same edge, so they never show a mismatched digit.

## Timing
- Compare latency: 1 cycle. in_valid high at edge N gives out/out_valid/counter update visible after edge N.
- Back-to-back in_valid is accepted every cycle; there is no backpressure.
- Display latency: 1 cycle from counter/disp_sel change to seg7. Each digit dwell is exactly SCAN_DIV cycles.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The scan restarts at digit 0 after release.
- clr does not disturb the scan position.

## Structure
- Package cmp_scoreboard_pkg holds:
  - result codes (RES_NONE=00, RES_GT=01, RES_LT=10, RES_EQ=11)
  - disp_sel codes
  - active-low glyph constants
- One sub-module, hex_to_seg7: combinational 4-bit nibble plus dp flag to 8-bit active-low glyph.
- Top holds the compare register, the counters and the scan logic.

## Test plan
- Reset: hold rst=1 → out=00, out_valid=0, seg7=C0, an=2'b10; after release, an toggles every 4 cycles.
- Unsigned sequence, one sample per cycle: (8,4) (F,0) (9,B) (C,C) → out 01, 01, 10, 11 on successive cycles; counters gt=2, lt=1, eq=1.
- Signed mode, a=4'b1000, b=4'b0100 → out=10. The same operands unsigned → out=01.
- Display after gt=2 with disp_sel=00 → digit0 seg7=A4, digit1 seg7=C0. Switching disp_sel=10 → digit0 shows 8'hF9 ("1").
- Saturation: 260 gt samples → gt counter = 8'hFF; digit0 seg7=8'h0E (F with dp lit), digit1=8'h8E; further samples still pulse out_valid.
- clr together with in_valid (a=F, b=0) → counters 0, out=00, no out_valid. rst asserted mid-scan on digit1 → an=2'b10 and seg7=C0 with no clock edge needed.
